seg7_scan_ctrl: RTL and testbench

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

---
 rtl/seg7_scan_ctrl_pkg.sv | 36 +++
 rtl/seg7_scan_ctrl_hex_to_seg7.sv | 33 +++
 rtl/seg7_scan_ctrl.sv | 174 +++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared definitions for the multiplexed 7-segment scan controller:
// FSM state encoding, segment bit order and the hex glyph set.
package seg7_scan_ctrl_pkg;

  typedef enum logic {
    ST_GUARD = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_e;

  // Segment bit positions within seg[6:0] = {g,f,e,d,c,b,a}
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;
  localparam logic [6:0] GLYPH_A = 7'h77;
  localparam logic [6:0] GLYPH_B = 7'h7C;
  localparam logic [6:0] GLYPH_C = 7'h39;
  localparam logic [6:0] GLYPH_D = 7'h5E;
  localparam logic [6:0] GLYPH_E = 7'h79;
  localparam logic [6:0] GLYPH_F = 7'h71;

endpackage

// File: rtl/seg7_scan_ctrl_hex_to_seg7.sv
// Combinational hex nibble to 7-segment glyph decoder.
module hex_to_seg7
  import seg7_scan_ctrl_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  // Map each nibble value to its standard hex glyph
  always_comb begin
    glyph = GLYPH_0;
    case (nibble)
      4'h0:    glyph = GLYPH_0;
      4'h1:    glyph = GLYPH_1;
      4'h2:    glyph = GLYPH_2;
      4'h3:    glyph = GLYPH_3;
      4'h4:    glyph = GLYPH_4;
      4'h5:    glyph = GLYPH_5;
      4'h6:    glyph = GLYPH_6;
      4'h7:    glyph = GLYPH_7;
      4'h8:    glyph = GLYPH_8;
      4'h9:    glyph = GLYPH_9;
      4'hA:    glyph = GLYPH_A;
      4'hB:    glyph = GLYPH_B;
      4'hC:    glyph = GLYPH_C;
      4'hD:    glyph = GLYPH_D;
      4'hE:    glyph = GLYPH_E;
      4'hF:    glyph = GLYPH_F;
      default: glyph = 7'h00;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with ghost blanking
// and tear-free, frame-synchronous display updates.
module seg7_scan_ctrl
  import seg7_scan_ctrl_pkg::*;
#(
  parameter int DIV   = 50000,
  parameter int GUARD = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] data_in,
  input  logic [3:0]  blank_in,
  input  logic [3:0]  dp_in,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        upd_done
);

  localparam int MAXP = (DIV > GUARD) ? DIV : GUARD;
  localparam int CW   = (MAXP > 1) ? $clog2(MAXP) : 1;
  localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 32'sd1);
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD - 32'sd1);
  localparam logic [CW-1:0] CNT_ZERO   = CW'(32'd0);
  localparam logic [CW-1:0] CNT_ONE    = CW'(32'd1);

  scan_state_e   state_r;
  logic [1:0]    idx_r;
  logic [CW-1:0] cnt_r;

  logic [15:0]   disp_r;
  logic [3:0]    blank_r;
  logic [3:0]    dpm_r;
  logic [15:0]   pend_data_r;
  logic [3:0]    pend_blank_r;
  logic [3:0]    pend_dp_r;
  logic          pend_valid_r;

  scan_state_e   nxt_state_s;
  logic [1:0]    nxt_idx_s;
  logic [CW-1:0] nxt_cnt_s;
  logic          commit_s;
  logic [15:0]   nxt_disp_s;
  logic [3:0]    nxt_blank_s;
  logic [3:0]    nxt_dpm_s;
  logic [3:0]    nib_s;
  logic [6:0]    glyph_s;

  // Next scan position; commits only at the frame boundary or while dark
  always_comb begin
    nxt_state_s = state_r;
    nxt_idx_s   = idx_r;
    nxt_cnt_s   = cnt_r;
    commit_s    = 1'b0;
    if (!en) begin
      nxt_state_s = ST_GUARD;
      nxt_idx_s   = 2'd0;
      nxt_cnt_s   = CNT_ZERO;
      commit_s    = pend_valid_r;
    end else begin
      case (state_r)
        ST_GUARD: begin
          if (cnt_r == GUARD_LAST) begin
            nxt_state_s = ST_DRIVE;
            nxt_cnt_s   = CNT_ZERO;
          end else begin
            nxt_cnt_s   = cnt_r + CNT_ONE;
          end
        end
        ST_DRIVE: begin
          if (cnt_r == DIV_LAST) begin
            nxt_state_s = ST_GUARD;
            nxt_idx_s   = idx_r + 2'd1;
            nxt_cnt_s   = CNT_ZERO;
            commit_s    = pend_valid_r && (idx_r == 2'd3);
          end else begin
            nxt_cnt_s   = cnt_r + CNT_ONE;
          end
        end
        default: begin
          nxt_state_s = ST_GUARD;
          nxt_idx_s   = 2'd0;
          nxt_cnt_s   = CNT_ZERO;
        end
      endcase
    end
  end

  // Display contents as they will be after this edge, for output lookahead
  always_comb begin
    nxt_disp_s  = commit_s ? pend_data_r  : disp_r;
    nxt_blank_s = commit_s ? pend_blank_r : blank_r;
    nxt_dpm_s   = commit_s ? pend_dp_r    : dpm_r;
    nib_s       = nxt_disp_s[{nxt_idx_s, 2'b00} +: 4];
  end

  hex_to_seg7 u_hex_to_seg7 (
    .nibble (nib_s),
    .glyph  (glyph_s)
  );

  // Scan FSM state, phase counter and digit index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_GUARD;
      idx_r   <= 2'd0;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= nxt_state_s;
      idx_r   <= nxt_idx_s;
      cnt_r   <= nxt_cnt_s;
    end
  end

  // Pending buffer: latest load wins; a load on the commit edge stays pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_data_r  <= 16'h0000;
      pend_blank_r <= 4'b0000;
      pend_dp_r    <= 4'b0000;
      pend_valid_r <= 1'b0;
    end else if (load) begin
      pend_data_r  <= data_in;
      pend_blank_r <= blank_in;
      pend_dp_r    <= dp_in;
      pend_valid_r <= 1'b1;
    end else if (commit_s) begin
      pend_valid_r <= 1'b0;
    end else begin
      pend_valid_r <= pend_valid_r;
    end
  end

  // Display register, updated only on commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_r  <= 16'h0000;
      blank_r <= 4'b0000;
      dpm_r   <= 4'b0000;
    end else if (commit_s) begin
      disp_r  <= pend_data_r;
      blank_r <= pend_blank_r;
      dpm_r   <= pend_dp_r;
    end else begin
      disp_r  <= disp_r;
      blank_r <= blank_r;
      dpm_r   <= dpm_r;
    end
  end

  // Registered pad outputs derived from the next state so they track it exactly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an       <= 4'b1111;
      seg      <= 7'h00;
      dp       <= 1'b0;
      upd_done <= 1'b0;
    end else begin
      upd_done <= commit_s;
      if (nxt_state_s == ST_DRIVE) begin
        an  <= ~(4'b0001 << nxt_idx_s);
        seg <= nxt_blank_s[nxt_idx_s] ? 7'h00 : glyph_s;
        dp  <= nxt_dpm_s[nxt_idx_s] & ~nxt_blank_s[nxt_idx_s];
      end else begin
        an  <= 4'b1111;
        seg <= 7'h00;
        dp  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: a frame-position reference model
// queues expected outputs per edge, a monitor pops and compares them.
module tb_seg7_scan_ctrl;

  localparam int DIV   = 4;
  localparam int GUARD = 2;
  localparam int SLOT  = GUARD + DIV;
  localparam int FRAME = 4 * SLOT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] data_in = 16'h0000;
  logic [3:0]  blank_in = 4'b0000;
  logic [3:0]  dp_in = 4'b0000;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        upd_done;

  seg7_scan_ctrl #(.DIV(DIV), .GUARD(GUARD)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .data_in(data_in),
    .blank_in(blank_in), .dp_in(dp_in), .an(an), .seg(seg), .dp(dp),
    .upd_done(upd_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       upd;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  // Reference model state: position within the frame plus buffers
  int          m_pos = 0;
  logic [15:0] m_disp = 16'h0, m_pd = 16'h0;
  logic [3:0]  m_blk = 4'h0, m_dpr = 4'h0, m_pb = 4'h0, m_pp = 4'h0;
  bit          m_pv = 1'b0;

  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    logic [6:0] t [16];
    t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return t[v];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit en_v, input bit ld,
                            input logic [15:0] d, input logic [3:0] b, input logic [3:0] p);
    exp_t e;
    bit upd;
    int slot;
    upd = 1'b0;
    if (rst) begin
      m_pos = 0; m_disp = 16'h0; m_blk = 4'h0; m_dpr = 4'h0; m_pv = 1'b0;
    end else begin
      if (!en_v || m_pos == FRAME - 1) begin
        m_pos = 0;
        if (m_pv) begin
          m_disp = m_pd; m_blk = m_pb; m_dpr = m_pp; m_pv = 1'b0; upd = 1'b1;
        end
      end else begin
        m_pos++;
      end
      if (ld) begin
        m_pd = d; m_pb = b; m_pp = p; m_pv = 1'b1;
      end
    end
    slot = m_pos / SLOT;
    if (m_pos % SLOT < GUARD) begin
      e.an = 4'b1111; e.seg = 7'h00; e.dp = 1'b0;
    end else begin
      e.an = 4'b1111;
      e.an[slot] = 1'b0;
      e.seg = m_blk[slot] ? 7'h00 : hex_glyph(m_disp[slot*4 +: 4]);
      e.dp  = m_dpr[slot] && !m_blk[slot];
    end
    e.upd = upd;
    exp_q.push_back(e);
  endtask

  task automatic cycle(input bit rst, input bit en_v, input bit ld,
                       input logic [15:0] d, input logic [3:0] b, input logic [3:0] p);
    @(negedge clk);
    rst_n = !rst; en = en_v; load = ld; data_in = d; blank_in = b; dp_in = p;
    if (rst) begin
      #1;
      check("async_reset_an", {28'd0, an}, 32'hF);
      check("async_reset_upd", {31'd0, upd_done}, 32'h0);
    end
    model_step(rst, en_v, ld, d, b, p);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
  endtask

  task automatic run_until(input int target);
    int n;
    n = 0;
    while (m_pos != target && n < 3 * FRAME) begin
      idle(1);
      n++;
    end
    check("run_until_reached", m_pos, target);
  endtask

  // Monitor: compare each edge's outputs with the queued expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("an", {28'd0, an}, {28'd0, e.an});
        check("seg", {25'd0, seg}, {25'd0, e.seg});
        check("dp", {31'd0, dp}, {31'd0, e.dp});
        check("upd_done", {31'd0, upd_done}, {31'd0, e.upd});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    int off_cnt;
    bit en_v, ld;
    repeat (3) @(posedge clk);
    #1;
    check("reset_an", {28'd0, an}, 32'hF);
    check("reset_seg", {25'd0, seg}, 32'h0);
    check("reset_dp", {31'd0, dp}, 32'h0);
    check("reset_upd", {31'd0, upd_done}, 32'h0);

    // Plain scan of 0000
    idle(2 * FRAME + 3);

    // Load mid-frame, visible only from the next frame
    run_until(8);
    cycle(1'b0, 1'b1, 1'b1, 16'h1A2F, 4'h0, 4'h0);
    idle(2 * FRAME);

    // Two loads in one frame: latest wins
    run_until(3);
    cycle(1'b0, 1'b1, 1'b1, 16'h1111, 4'h0, 4'h0);
    idle(3);
    cycle(1'b0, 1'b1, 1'b1, 16'h2222, 4'h0, 4'h0);
    idle(2 * FRAME);

    // Load on the boundary cycle while another is pending
    run_until(5);
    cycle(1'b0, 1'b1, 1'b1, 16'h1111, 4'h0, 4'h0);
    run_until(FRAME - 1);
    cycle(1'b0, 1'b1, 1'b1, 16'h3333, 4'h0, 4'h0);
    idle(2 * FRAME + 2);

    // Blanked digit and decimal point
    cycle(1'b0, 1'b1, 1'b1, 16'h1234, 4'b0100, 4'b0001);
    idle(2 * FRAME);

    // Disable during digit 2 drive, load while dark, then re-enable
    run_until(15);
    cycle(1'b0, 1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
    cycle(1'b0, 1'b0, 1'b1, 16'hBEEF, 4'h0, 4'h0);
    cycle(1'b0, 1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
    cycle(1'b0, 1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
    idle(FRAME + 4);

    // Reset mid-frame with data pending
    run_until(10);
    cycle(1'b0, 1'b1, 1'b1, 16'h5678, 4'h0, 4'hF);
    cycle(1'b1, 1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    cycle(1'b1, 1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    idle(FRAME + 6);

    // Randomized traffic
    off_cnt = 0;
    for (int i = 0; i < 1500; i++) begin
      if (off_cnt > 0) begin
        off_cnt--;
        en_v = 1'b0;
      end else if ($urandom_range(0, 39) == 0) begin
        off_cnt = $urandom_range(1, 5);
        en_v = 1'b0;
      end else begin
        en_v = 1'b1;
      end
      ld = ($urandom_range(0, 14) == 0);
      cycle(1'b0, en_v, ld, 16'($urandom), 4'($urandom), 4'($urandom));
    end

    @(posedge clk);
    #2;
    check("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
